// File: rtl/tt_check_pkg.sv
// tt_check_pkg: shared FSM states, signature polynomial and fold/LFSR helpers for truth_table_checker.
package tt_check_pkg;
  typedef enum logic [1:0] {IDLE, SETTLE, CHECK, DONE} tt_state_t;
  localparam logic [15:0] SIG_POLY = 16'h1021;
  function automatic logic [15:0] fold16(input logic [31:0] a_in);
    return a_in[15:0] ^ a_in[31:16];
  endfunction
  // Galois step of x^16+x^12+x^5+1
  function automatic logic [15:0] lfsr16(input logic [15:0] s);
    return {s[14:0], 1'b0} ^ (s[15] ? SIG_POLY : 16'h0000);
  endfunction
endpackage

// File: rtl/tt_signature.sv
// tt_signature: 16-bit Galois LFSR signature with clear and enable, used when TT_SIGNATURE_EN is defined.
module tt_signature
  import tt_check_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        clr,
  input  logic        en,
  input  logic [15:0] din,
  output logic [15:0] sig
);
  always_ff @(posedge clk)
    if (reset || clr) sig <= '0;
    else if (en) sig <= lfsr16(sig ^ din);
endmodule

// File: rtl/truth_table_checker.sv
// truth_table_checker: sweeps all input vectors into two implementations and accumulates mismatch results.
// Optional a_in signature enabled by defining TT_SIGNATURE_EN; otherwise sig is tied to zero.
module truth_table_checker
  import tt_check_pkg::*;
#(
  parameter int N_IN         = 3,
  parameter int N_OUT        = 1,
  parameter int SETTLE       = 1,
  parameter int STOP_ON_FAIL = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  output logic [N_IN-1:0]  vec,
  input  logic [N_OUT-1:0] a_in,
  input  logic [N_OUT-1:0] b_in,
  output logic             busy,
  output logic             done,
  output logic [N_IN:0]    err_count,
  output logic [N_OUT-1:0] fail_mask,
  output logic [N_IN-1:0]  first_fail_vec,
  output logic             first_fail_vld,
  output logic [15:0]      sig
);
  localparam int CW = $clog2(SETTLE + 1);
  tt_state_t state, nxt;
  logic [CW-1:0] cnt;
  logic [N_OUT-1:0] mm;
  logic accept, settled, last, in_settle, in_check;
  assign mm = a_in ^ b_in;
  assign in_settle = state == tt_check_pkg::SETTLE;
  assign in_check = state == CHECK;
  assign accept = start && (state == IDLE || state == DONE);
  assign settled = cnt == CW'(SETTLE - 1);
  assign last = (&vec) || (STOP_ON_FAIL != 0 && |mm);
  always_comb begin
    nxt = state;
    nxt = accept ? tt_check_pkg::SETTLE :
          in_settle ? (settled ? CHECK : tt_check_pkg::SETTLE) :
          in_check ? (last ? DONE : tt_check_pkg::SETTLE) : state;
  end
  always_ff @(posedge clk)
    if (reset) begin
      state <= IDLE;
      cnt <= '0;
      vec <= '0;
      busy <= 1'b0;
      done <= 1'b0;
      err_count <= '0;
      fail_mask <= '0;
      first_fail_vec <= '0;
      first_fail_vld <= 1'b0;
    end else begin
      state <= nxt;
      if (accept) begin
        cnt <= '0;
        vec <= '0;
        busy <= 1'b1;
        done <= 1'b0;
        err_count <= '0;
        fail_mask <= '0;
        first_fail_vec <= '0;
        first_fail_vld <= 1'b0;
      end else if (in_settle) begin
        cnt <= settled ? '0 : cnt + 1'b1;
      end else if (in_check) begin
        fail_mask <= fail_mask | mm;
        if (|mm) err_count <= err_count + 1'b1;
        if (|mm && !first_fail_vld) begin
          first_fail_vec <= vec;
          first_fail_vld <= 1'b1;
        end
        if (last) begin
          busy <= 1'b0;
          done <= 1'b1;
        end else vec <= vec + 1'b1;
      end
    end
`ifdef TT_SIGNATURE_EN
  tt_signature u_sig (
    .clk(clk),
    .reset(reset),
    .clr(accept),
    .en(in_check),
    .din(fold16(32'(a_in))),
    .sig(sig)
  );
`else
  assign sig = 16'h0000;
`endif
endmodule

// File: tb/tb_truth_table_checker.sv
// tb_truth_table_checker: table-driven sweeps on three checker configurations plus reset/restart sequences.
module tb_truth_table_checker;
  logic clk = 1'b0, reset = 1'b1;
  logic start[3];
  logic [15:0] flt[3];
  logic [2:0] vec_w[3], ffv_w[3];
  logic busy_w[3], done_w[3], vld_w[3];
  logic [3:0] err_w[3];
  logic [1:0] mask_w[3], a_full[3], b_full[3];
  logic [15:0] sig_w[3];
  logic m0, m1;
  int pass_n = 0, tot = 0;

  always #5 clk = ~clk;

  function automatic logic [1:0] fa(int d, logic [2:0] v);
    return d == 2 ? {v[0] & v[1], ^v} : {1'b0, ^v};
  endfunction

  for (genvar g = 0; g < 3; g++) begin : g_stim
    assign a_full[g] = fa(g, vec_w[g]);
    assign b_full[g] = a_full[g] ^ flt[g][2*vec_w[g] +: 2];
  end
  assign mask_w[0] = {1'b0, m0};
  assign mask_w[1] = {1'b0, m1};

  truth_table_checker #(.N_IN(3), .N_OUT(1), .SETTLE(1), .STOP_ON_FAIL(0)) dut0 (
    .clk(clk), .reset(reset), .start(start[0]), .vec(vec_w[0]), .a_in(a_full[0][0]), .b_in(b_full[0][0]),
    .busy(busy_w[0]), .done(done_w[0]), .err_count(err_w[0]), .fail_mask(m0),
    .first_fail_vec(ffv_w[0]), .first_fail_vld(vld_w[0]), .sig(sig_w[0]));
  truth_table_checker #(.N_IN(3), .N_OUT(1), .SETTLE(1), .STOP_ON_FAIL(1)) dut1 (
    .clk(clk), .reset(reset), .start(start[1]), .vec(vec_w[1]), .a_in(a_full[1][0]), .b_in(b_full[1][0]),
    .busy(busy_w[1]), .done(done_w[1]), .err_count(err_w[1]), .fail_mask(m1),
    .first_fail_vec(ffv_w[1]), .first_fail_vld(vld_w[1]), .sig(sig_w[1]));
  truth_table_checker #(.N_IN(3), .N_OUT(2), .SETTLE(1), .STOP_ON_FAIL(0)) dut2 (
    .clk(clk), .reset(reset), .start(start[2]), .vec(vec_w[2]), .a_in(a_full[2]), .b_in(b_full[2]),
    .busy(busy_w[2]), .done(done_w[2]), .err_count(err_w[2]), .fail_mask(mask_w[2]),
    .first_fail_vec(ffv_w[2]), .first_fail_vld(vld_w[2]), .sig(sig_w[2]));

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    tot++;
    if (act === exp) pass_n++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  function automatic logic [15:0] sig_model(int d, int vend);
    logic [15:0] s = '0, x;
`ifdef TT_SIGNATURE_EN
    for (int v = 0; v <= vend; v++) begin
      x = s ^ {14'b0, fa(d, 3'(v))};
      s = {x[14:0], 1'b0};
      if (x[15]) s = s ^ 16'h1021;
    end
`endif
    return s;
  endfunction

  // Pulse start, check the accept cleared results, then count cycles until done (bounded).
  task automatic run(int d, output int n);
    @(negedge clk) start[d] = 1'b1;
    @(posedge clk) #1 start[d] = 1'b0;
    chk("busy_after_start", busy_w[d], 1);
    chk("done_cleared", done_w[d], 0);
    chk("err_cleared", err_w[d], 0);
    n = 0;
    while (n < 200) begin
      @(posedge clk) #1 n++;
      if (done_w[d]) break;
    end
    chk("done_within_bound", done_w[d], 1);
  endtask

  typedef struct {
    int d; logic [15:0] f; int err; int mask; int ffv; int vld; int vend; int cyc;
  } row_t;
  row_t tbl[8];

  initial begin
    int n;
    for (int d = 0; d < 3; d++) begin start[d] = 1'b0; flt[d] = '0; end
    tbl[0] = '{0, 16'h0000, 0, 0, 0, 0, 7, 16};
    tbl[1] = '{0, 16'h0400, 1, 1, 5, 1, 7, 16};
    tbl[2] = '{1, 16'h1010, 1, 1, 2, 1, 2, 6};
    tbl[3] = '{2, 16'h00C8, 2, 3, 1, 1, 7, 16};
    tbl[4] = '{1, 16'h0000, 0, 0, 0, 0, 7, 16};
    tbl[5] = '{1, 16'h4000, 1, 1, 7, 1, 7, 16};
    tbl[6] = '{2, 16'h0001, 1, 1, 0, 1, 7, 16};
    tbl[7] = '{0, 16'h5555, 8, 1, 0, 1, 7, 16};
    repeat (3) @(posedge clk);
    #1;
    for (int d = 0; d < 3; d++) begin
      chk("rst_vec", vec_w[d], 0);
      chk("rst_busy_done", {busy_w[d], done_w[d], vld_w[d]}, 0);
      chk("rst_err_mask", {err_w[d], mask_w[d], ffv_w[d]}, 0);
      chk("rst_sig", sig_w[d], 0);
    end
    @(negedge clk) reset = 1'b0;
    for (int i = 0; i < 8; i++) begin
      flt[tbl[i].d] = tbl[i].f;
      run(tbl[i].d, n);
      chk("cycles", n, tbl[i].cyc);
      chk("err_count", err_w[tbl[i].d], tbl[i].err);
      chk("fail_mask", mask_w[tbl[i].d], tbl[i].mask);
      chk("first_fail_vec", ffv_w[tbl[i].d], tbl[i].ffv);
      chk("first_fail_vld", vld_w[tbl[i].d], tbl[i].vld);
      chk("vec_at_done", vec_w[tbl[i].d], tbl[i].vend);
      chk("busy_at_done", busy_w[tbl[i].d], 0);
      chk("sig", sig_w[tbl[i].d], sig_model(tbl[i].d, tbl[i].vend));
    end
    // results hold in DONE
    repeat (3) @(posedge clk);
    #1;
    chk("done_hold", done_w[0], 1);
    chk("err_hold", err_w[0], 8);
    // start while busy is ignored
    flt[0] = 16'h0400;
    @(negedge clk) start[0] = 1'b1;
    @(posedge clk) #1 start[0] = 1'b0;
    n = 0;
    while (n < 200) begin
      @(posedge clk) #1 n++;
      start[0] = (n == 5);
      if (done_w[0]) break;
    end
    start[0] = 1'b0;
    chk("busy_start_cycles", n, 16);
    chk("busy_start_err", err_w[0], 1);
    chk("busy_start_ffv", ffv_w[0], 5);
    // reset mid-sweep at vec==4
    flt[0] = 16'h0004;
    @(negedge clk) start[0] = 1'b1;
    @(posedge clk) #1 start[0] = 1'b0;
    n = 0;
    while (vec_w[0] != 3'd4 && n < 100) begin @(posedge clk) #1 n++; end
    chk("reached_vec4", vec_w[0], 4);
    chk("mid_err", err_w[0], 1);
    @(negedge clk) reset = 1'b1;
    @(posedge clk) #1;
    chk("mid_rst_vec", vec_w[0], 0);
    chk("mid_rst_flags", {busy_w[0], done_w[0], vld_w[0]}, 0);
    chk("mid_rst_err", {err_w[0], mask_w[0], ffv_w[0]}, 0);
    chk("mid_rst_sig", sig_w[0], 0);
    @(negedge clk) start[0] = 1'b1;
    @(posedge clk) #1;
    chk("start_with_reset", busy_w[0], 0);
    @(negedge clk) begin reset = 1'b0; start[0] = 1'b0; end
    repeat (3) @(posedge clk);
    #1;
    chk("idle_after_reset", {busy_w[0], done_w[0]}, 0);
    flt[0] = 16'h0000;
    run(0, n);
    chk("rerun_cycles", n, 16);
    chk("rerun_err", err_w[0], 0);
    chk("rerun_vec", vec_w[0], 7);
    $display("%0d/%0d checks passed", pass_n, tot);
    $finish;
  end
endmodule
